// File: rtl/ta_bank.sv
// One Tsetlin Machine clause: a bank of NUM_TA two-action automata, evaluated in one cycle and trained serially.
// Optional BOOST_TRUE_POSITIVE_EN: Type I feedback on a true literal of a firing clause always increments.
module ta_bank #(
  parameter int NUM_TA     = 8,
  parameter int STATE_BITS = 3,
  parameter int RAND_BITS  = 8,
  parameter int S_THRESH   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  input  logic                 mode,
  input  logic [NUM_TA-1:0]    literals,
  input  logic                 feedback_en,
  input  logic                 feedback_type,
  input  logic [RAND_BITS-1:0] rand_in,
  output logic                 clause_out,
  output logic [NUM_TA-1:0]    include_out,
  output logic                 done
);

  localparam int IDX_W = (NUM_TA > 1) ? $clog2(NUM_TA) : 1;
  localparam logic [STATE_BITS-1:0] ST_RESET = {1'b0, {(STATE_BITS-1){1'b1}}};
  localparam logic [STATE_BITS-1:0] ST_MAX   = {STATE_BITS{1'b1}};
  localparam logic [RAND_BITS-1:0]  S_TH     = RAND_BITS'(S_THRESH);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_TA - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_UPD, S_FIN} fsm_t;

  fsm_t                  fsm;
  logic [IDX_W-1:0]      idx;
  logic [STATE_BITS-1:0] ta_state [NUM_TA];
  logic                  mode_p0;
  logic                  fb_en_p0;
  logic                  fb_type_p0;
  logic [NUM_TA-1:0]     lits_p0;
  logic [NUM_TA-1:0]     include_vec;
  logic                  clause_eval;
  logic [STATE_BITS-1:0] upd_next;

  function automatic logic [STATE_BITS-1:0] sat_inc(input logic [STATE_BITS-1:0] s);
    return (s == ST_MAX) ? s : s + 1'b1;
  endfunction

  function automatic logic [STATE_BITS-1:0] sat_dec(input logic [STATE_BITS-1:0] s);
    return (s == '0) ? s : s - 1'b1;
  endfunction

  // Feedback rule for one automaton; rnd below S_TH is the 1/s event.
  function automatic logic [STATE_BITS-1:0] ta_next(
    input logic [STATE_BITS-1:0] s,
    input logic                  lit,
    input logic                  clause,
    input logic                  ftype,
    input logic [RAND_BITS-1:0]  rnd
  );
    logic low;
    low     = (rnd < S_TH);
    ta_next = s;
    if (!ftype) begin
      if (clause && lit) begin
`ifdef BOOST_TRUE_POSITIVE_EN
        ta_next = sat_inc(s);
`else
        if (!low) ta_next = sat_inc(s);
`endif
      end else if (low) begin
        ta_next = sat_dec(s);
      end
    end else if (clause && !lit && !s[STATE_BITS-1]) begin
      ta_next = sat_inc(s);
    end
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_TA; g++) begin : g_inc
      assign include_vec[g] = ta_state[g][STATE_BITS-1];
    end
  endgenerate

  assign include_out = include_vec;

  // An empty clause reads as 0 when inferring but 1 while training, so learning can start.
  always_comb begin
    clause_eval = mode_p0;
    if (|include_vec) clause_eval = &(lits_p0 | ~include_vec);
  end

  always_comb begin
    upd_next = ta_next(ta_state[idx], lits_p0[idx], clause_out, fb_type_p0, rand_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= S_IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      clause_out <= 1'b0;
      idx        <= '0;
      mode_p0    <= 1'b0;
      fb_en_p0   <= 1'b0;
      fb_type_p0 <= 1'b0;
      for (int k = 0; k < NUM_TA; k++) ta_state[k] <= ST_RESET;
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start && ready) begin
            mode_p0    <= mode;
            lits_p0    <= literals;
            fb_en_p0   <= feedback_en;
            fb_type_p0 <= feedback_type;
            idx        <= '0;
            ready      <= 1'b0;
            fsm        <= S_EVAL;
          end
        end
        // EVAL -> UPD / FIN
        S_EVAL: begin
          clause_out <= clause_eval;
          if (mode_p0 && fb_en_p0) begin
            fsm <= S_UPD;
          end else begin
            fsm  <= S_FIN;
            done <= 1'b1;
          end
        end
        // UPD -> FIN after the last automaton
        S_UPD: begin
          ta_state[idx] <= upd_next;
          idx           <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            fsm  <= S_FIN;
            done <= 1'b1;
          end
        end
        S_FIN: begin
          fsm   <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          fsm   <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
